// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile sequencer.
package systolic_pkg;

  localparam int N_DEF      = 8;
  localparam int ADDR_W_DEF = 13;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    DRAIN,
    NEXT,
    DONE
  } tile_state_e;

  typedef struct packed {
    logic [7:0] m_tiles;
    logic [7:0] n_tiles;
    logic [7:0] k;
    logic       out_mode;
  } tile_cmd_t;

endpackage

// File: rtl/systolic_tile_addr_gen.sv
// Row-major tile walker: row/col counters and incrementally maintained A/B/C tile bases.
module systolic_tile_addr_gen
  import systolic_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  input  logic [7:0]        k,
  input  logic [7:0]        m_tiles,
  input  logic [7:0]        n_tiles,
  output logic              last_tile,
  output logic [7:0]        tile_row,
  output logic [7:0]        tile_col,
  output logic [ADDR_W-1:0] a_tile_base,
  output logic [ADDR_W-1:0] b_tile_base,
  output logic [ADDR_W-1:0] c_tile_base
);

  logic [ADDR_W-1:0] b_base_q;
  logic [ADDR_W-1:0] k_ext;
  logic              last_col;

  assign k_ext     = ADDR_W'(k);
  assign last_col  = (tile_col == n_tiles - 8'd1);
  assign last_tile = last_col && (tile_row == m_tiles - 8'd1);

  // Row-major order means C always advances by one tile stride, even across rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_row    <= '0;
      tile_col    <= '0;
      a_tile_base <= '0;
      b_tile_base <= '0;
      c_tile_base <= '0;
      b_base_q    <= '0;
    end else if (init) begin
      tile_row    <= '0;
      tile_col    <= '0;
      a_tile_base <= a_base;
      b_tile_base <= b_base;
      c_tile_base <= c_base;
      b_base_q    <= b_base;
    end else if (step) begin
      c_tile_base <= c_tile_base + ADDR_W'(N);
      if (last_col) begin
        tile_col    <= '0;
        tile_row    <= tile_row + 8'd1;
        a_tile_base <= a_tile_base + k_ext;
        b_tile_base <= b_base_q;
      end else begin
        tile_col    <= tile_col + 8'd1;
        b_tile_base <= b_tile_base + k_ext;
      end
    end
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Sequences the NxN systolic array over all output tiles of a tiled matmul command.
module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_m_tiles,
  input  logic [7:0]        cmd_n_tiles,
  input  logic [7:0]        cmd_k,
  input  logic              cmd_out_mode,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  input  logic [ADDR_W-1:0] cmd_c_base,
  input  logic              abort,
  output logic              arr_start,
  output logic              arr_clear,
  output logic [7:0]        arr_k_param,
  output logic              arr_out_mode,
  input  logic              arr_calc_done,
  input  logic              arr_dout_done,
  output logic [ADDR_W-1:0] a_tile_base,
  output logic [ADDR_W-1:0] b_tile_base,
  output logic [ADDR_W-1:0] c_tile_base,
  output logic [7:0]        tile_row,
  output logic [7:0]        tile_col,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted
);

  tile_state_e state;
  tile_cmd_t   cmd_q;
  logic        abort_pending;
  logic        last_tile;
  logic        accept;
  logic        finish_now;
  logic        advance;
  logic        bad_cmd;

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign arr_k_param  = cmd_q.k;
  assign arr_out_mode = cmd_q.out_mode;

  always_comb begin
    accept     = cmd_valid && (state == IDLE);
    bad_cmd    = (cmd_m_tiles == 8'd0) || (cmd_n_tiles == 8'd0) || (cmd_k == 8'd0);
    // abort arriving in NEXT itself is honoured at this boundary too
    finish_now = last_tile || abort_pending || abort;
    advance    = (state == NEXT) && !finish_now;
  end

  systolic_tile_addr_gen #(.N(N), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (accept),
    .step       (advance),
    .a_base     (cmd_a_base),
    .b_base     (cmd_b_base),
    .c_base     (cmd_c_base),
    .k          (cmd_q.k),
    .m_tiles    (cmd_q.m_tiles),
    .n_tiles    (cmd_q.n_tiles),
    .last_tile  (last_tile),
    .tile_row   (tile_row),
    .tile_col   (tile_col),
    .a_tile_base(a_tile_base),
    .b_tile_base(b_tile_base),
    .c_tile_base(c_tile_base)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_q         <= '0;
      abort_pending <= 1'b0;
      arr_start     <= 1'b0;
      arr_clear     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      arr_start <= 1'b0;
      arr_clear <= 1'b0;
      done      <= 1'b0;
      if (state != IDLE && abort) abort_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q <= '{m_tiles: cmd_m_tiles, n_tiles: cmd_n_tiles,
                       k: cmd_k, out_mode: cmd_out_mode};
            if (bad_cmd) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= LOAD;
              arr_start <= 1'b1;
            end
          end
        end
        LOAD: state <= CALC;
        CALC: begin
          if (arr_calc_done) begin
            state     <= DRAIN;
            arr_clear <= 1'b1;
          end
        end
        DRAIN: begin
          if (arr_dout_done) state <= NEXT;
        end
        NEXT: begin
          if (finish_now) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= abort_pending || abort;
          end else begin
            state     <= LOAD;
            arr_start <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          abort_pending <= 1'b0;
          err           <= 1'b0;
          aborted       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
